// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;
  localparam int unsigned LOCK_MAX_MIN     = 2;
  localparam int unsigned LOCK_MAX_MAX     = 255;

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side bus of the data-memory arbiter: command, grant and read return.
interface dmem_arb_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              lock;
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, lock, wren, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, wren, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arb_rdpipe.sv
// Valid/port-ID shift register that tracks in-flight reads across the memory latency.
module dmem_arb_rdpipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_port,
  output logic out_valid,
  output logic out_port
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] port_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      port_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      port_q[0]  <= in_port;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        port_q[i]  <= port_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_port  = port_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port dmem with burst locking and a lock watchdog.
// Define DMEM_ARB_RR_EN for round-robin arbitration in idle; default is port 0 first.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arb_if.slave         p0,
  dmem_arb_if.slave         p1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  arb_state_e state_q, state_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [8:0] cnt_inc;
  logic       fpri_q, fpri_d;
  logic       fport_q, fport_d;
  logic       last_q, last_d;

  logic gnt0, gnt1, any_gnt, gport, glock, gwren, owner_req;
  logic rd_valid, rd_port;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      StOwn0: gnt0 = p0.req;
      StOwn1: gnt1 = p1.req;
      default: begin
        if (p0.req && p1.req) begin
          // A forced release hands the next contested slot to the other port.
          if (fpri_q) begin
            gnt0 = (fport_q == PORT0);
            gnt1 = (fport_q == PORT1);
          end else begin
`ifdef DMEM_ARB_RR_EN
            gnt0 = (last_q == PORT1);
            gnt1 = (last_q == PORT0);
`else
            gnt0 = 1'b1;
`endif
          end
        end else begin
          gnt0 = p0.req;
          gnt1 = p1.req;
        end
      end
    endcase
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign gport     = gnt1 ? PORT1 : PORT0;
  assign glock     = gnt1 ? p1.lock : p0.lock;
  assign gwren     = gnt1 ? p1.wren : p0.wren;
  assign owner_req = (state_q == StOwn1) ? p1.req : p0.req;
  assign cnt_inc   = {1'b0, lock_cnt_q} + 9'd1;

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (gnt0) begin
      mem_address = p0.addr;
      mem_data    = p0.wdata;
      mem_wren    = p0.wren;
    end else if (gnt1) begin
      mem_address = p1.addr;
      mem_data    = p1.wdata;
      mem_wren    = p1.wren;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    fpri_d     = 1'b0;
    fport_d    = fport_q;
    last_d     = any_gnt ? gport : last_q;
    if (state_q != StIdle && !owner_req) begin
      state_d    = StIdle;
      lock_cnt_d = '0;
    end else if (any_gnt) begin
      if (glock) begin
        if (cnt_inc >= 9'(LOCK_MAX)) begin
          state_d    = StIdle;
          lock_cnt_d = '0;
          fpri_d     = 1'b1;
          fport_d    = ~gport;
        end else begin
          state_d    = gport ? StOwn1 : StOwn0;
          lock_cnt_d = cnt_inc[7:0];
        end
      end else begin
        state_d    = StIdle;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      fpri_q     <= 1'b0;
      fport_q    <= PORT0;
      last_q     <= PORT1;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      fpri_q     <= fpri_d;
      fport_q    <= fport_d;
      last_q     <= last_d;
    end
  end

  dmem_arb_rdpipe #(
    .DEPTH (READ_LATENCY)
  ) u_rdpipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (any_gnt & ~gwren),
    .in_port   (gport),
    .out_valid (rd_valid),
    .out_port  (rd_port)
  );

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = rd_valid && (rd_port == PORT0);
  assign p1.rvalid = rd_valid && (rd_port == PORT1);
  assign p0.rdata  = p0.rvalid ? mem_q : '0;
  assign p1.rdata  = p1.rvalid ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural single-cycle dmem.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

`ifdef DMEM_ARB_RR_EN
  localparam logic [3:0] EXP_G0 = 4'b0101;
`else
  localparam logic [3:0] EXP_G0 = 4'b1111;
`endif

  dmem_arb_if #(.ADDR_W(12), .DATA_W(32)) p0_if ();
  dmem_arb_if #(.ADDR_W(12), .DATA_W(32)) p1_if ();

  dmem_arbiter #(
    .ADDR_W       (12),
    .DATA_W       (32),
    .READ_LATENCY (1),
    .LOCK_MAX     (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .p0          (p0_if),
    .p1          (p1_if),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic req, input logic lock, input logic wren,
                      input logic [11:0] addr, input logic [31:0] wdata);
    p0_if.req = req; p0_if.lock = lock; p0_if.wren = wren;
    p0_if.addr = addr; p0_if.wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic lock, input logic wren,
                      input logic [11:0] addr, input logic [31:0] wdata);
    p1_if.req = req; p1_if.lock = lock; p1_if.wren = wren;
    p1_if.addr = addr; p1_if.wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic g;
    reset = 1'b1;
    drv0(0, 0, 0, 0, 0);
    drv1(1, 0, 0, 12'h030, 0);
    #2;
    check("rst_gnt1", p1_if.gnt, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_rvalid0", p0_if.rvalid, 0);
    check("rst_rdata1", p1_if.rdata, 0);
    tick();
    tick();
    reset = 1'b0;
    drv1(0, 0, 0, 0, 0);

    // Single write then read on port 0
    drv0(1, 0, 1, 12'h010, 32'hDEADBEEF);
    #2;
    check("wr_gnt0", p0_if.gnt, 1);
    check("wr_wren", mem_wren, 1);
    check("wr_addr", mem_address, 32'h010);
    check("wr_data", mem_data, 32'hDEADBEEF);
    check("wr_gnt1", p1_if.gnt, 0);
    tick();
    drv0(1, 0, 0, 12'h010, 0);
    #2;
    check("rd_gnt0", p0_if.gnt, 1);
    check("rd_wren", mem_wren, 0);
    check("rd_no_rvalid_wr", p0_if.rvalid, 0);
    tick();
    drv0(0, 0, 0, 0, 0);
    #2;
    check("rd_rvalid0", p0_if.rvalid, 1);
    check("rd_rdata0", p0_if.rdata, 32'hDEADBEEF);
    check("rd_rvalid1", p1_if.rvalid, 0);
    check("rd_rdata1", p1_if.rdata, 0);
    check("idle_addr", mem_address, 0);
    check("idle_data", mem_data, 0);
    tick();
    check("rd_done", p0_if.rvalid, 0);

    // Preload for contention
    drv0(1, 0, 1, 12'h020, 32'h12345678);
    #2;
    tick();
    drv0(0, 0, 0, 0, 0);
    drv1(1, 0, 1, 12'h030, 32'hA5A5A5A5);
    #2;
    check("pre_gnt1", p1_if.gnt, 1);
    tick();

    // Contention: both ports read every cycle for 4 cycles
    drv0(1, 0, 0, 12'h020, 0);
    drv1(1, 0, 0, 12'h030, 0);
    for (int i = 0; i < 4; i++) begin
      #2;
      g = EXP_G0[i];
      check("cont_gnt0", p0_if.gnt, g);
      check("cont_gnt1", p1_if.gnt, !g);
      check("cont_addr", mem_address, g ? 32'h020 : 32'h030);
      if (i > 0) begin
        g = EXP_G0[i-1];
        check("cont_rvalid0", p0_if.rvalid, g);
        check("cont_rvalid1", p1_if.rvalid, !g);
        check("cont_rdata0", p0_if.rdata, g ? 32'h12345678 : 32'h0);
        check("cont_rdata1", p1_if.rdata, g ? 32'h0 : 32'hA5A5A5A5);
      end
      tick();
    end
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    #2;
    g = EXP_G0[3];
    check("cont_last_rvalid0", p0_if.rvalid, g);
    check("cont_last_rvalid1", p1_if.rvalid, !g);
    tick();

    // Lock: port 1 owns for 3 beats while port 0 waits
    drv1(1, 1, 0, 12'h030, 0);
    #2;
    check("lock_gnt1_b0", p1_if.gnt, 1);
    tick();
    drv0(1, 0, 0, 12'h020, 0);
    for (int i = 1; i < 3; i++) begin
      #2;
      check("lock_gnt1", p1_if.gnt, 1);
      check("lock_gnt0", p0_if.gnt, 0);
      check("lock_rvalid1", p1_if.rvalid, 1);
      tick();
    end
    drv1(0, 0, 0, 0, 0);
    #2;
    check("lock_rel_gnt0", p0_if.gnt, 0);
    check("lock_rel_gnt1", p1_if.gnt, 0);
    tick();
    #2;
    check("lock_after_gnt0", p0_if.gnt, 1);
    tick();
    drv0(0, 0, 0, 0, 0);
    tick();

    // Watchdog: port 0 holds lock for LOCK_MAX grants, then port 1 goes next
    drv0(1, 1, 0, 12'h020, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 1) drv1(1, 0, 0, 12'h030, 0);
      #2;
      check("wd_gnt0", p0_if.gnt, 1);
      check("wd_gnt1", p1_if.gnt, 0);
      tick();
    end
    #2;
    check("wd_forced_gnt1", p1_if.gnt, 1);
    check("wd_forced_gnt0", p0_if.gnt, 0);
    tick();
    drv1(0, 0, 0, 0, 0);
    #2;
    check("wd_after_gnt0", p0_if.gnt, 1);
    tick();
    drv0(0, 0, 0, 0, 0);
    tick();
    tick();

    // Interleaved p0 writes and p1 reads of one address
    drv0(1, 0, 1, 12'h040, 32'hCAFEF00D);
    #2;
    check("wi_w0_wren", mem_wren, 1);
    tick();
    drv0(0, 0, 0, 0, 0);
    drv1(1, 0, 0, 12'h040, 0);
    #2;
    check("wi_r0_gnt1", p1_if.gnt, 1);
    check("wi_r0_wren", mem_wren, 0);
    check("wi_r0_rvalid0", p0_if.rvalid, 0);
    tick();
    drv1(0, 0, 0, 0, 0);
    drv0(1, 0, 1, 12'h040, 32'h0BADF00D);
    #2;
    check("wi_w1_wren", mem_wren, 1);
    check("wi_w1_rvalid1", p1_if.rvalid, 1);
    check("wi_w1_rdata1", p1_if.rdata, 32'hCAFEF00D);
    check("wi_w1_rdata0", p0_if.rdata, 0);
    tick();
    drv0(0, 0, 0, 0, 0);
    drv1(1, 0, 0, 12'h040, 0);
    #2;
    check("wi_r1_gnt1", p1_if.gnt, 1);
    check("wi_r1_wren", mem_wren, 0);
    check("wi_r1_rvalid0", p0_if.rvalid, 0);
    tick();
    drv1(0, 0, 0, 0, 0);
    #2;
    check("wi_r1_rvalid1", p1_if.rvalid, 1);
    check("wi_r1_rdata1", p1_if.rdata, 32'h0BADF00D);
    check("wi_r1_rvalid0b", p0_if.rvalid, 0);
    tick();

    // Reset with a read in flight
    drv0(1, 0, 0, 12'h010, 0);
    #2;
    check("mr_gnt0", p0_if.gnt, 1);
    tick();
    drv0(0, 0, 0, 0, 0);
    check("mr_rvalid_pre", p0_if.rvalid, 1);
    reset = 1'b1;
    drv1(1, 0, 1, 12'h050, 32'h1);
    #1;
    check("mr_rvalid0", p0_if.rvalid, 0);
    check("mr_rdata0", p0_if.rdata, 0);
    check("mr_gnt1", p1_if.gnt, 0);
    check("mr_wren", mem_wren, 0);
    tick();
    reset = 1'b0;
    drv1(0, 0, 0, 0, 0);
    #2;
    check("mr_post_rvalid0", p0_if.rvalid, 0);
    tick();
    #2;
    check("mr_post2_rvalid0", p0_if.rvalid, 0);
    check("mr_post2_rvalid1", p1_if.rvalid, 0);
    drv0(1, 0, 0, 12'h020, 0);
    drv1(1, 0, 0, 12'h030, 0);
    #1;
    check("mr_both_gnt0", p0_if.gnt, 1);
    check("mr_both_gnt1", p1_if.gnt, 0);
    tick();
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    #2;
    check("mr_new_rvalid0", p0_if.rvalid, 1);
    check("mr_new_rdata0", p0_if.rdata, 32'h12345678);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
